cnn_result_display_ctrl: RTL and testbench
==========================================

Name: cnn_result_display_ctrl

Overview:
- Sequences the CNN classifier's per-frame decisions onto the single 7-segment result digit.
- Collects a window of VOTE_N frame decisions and resolves them by majority vote, with error override.
- Drives the digit, then holds it for a programmable time, and re-arms automatically or on request.
- Sits between the classifier output stage and the board HEX display; replaces the one-shot latch-first-result scheme.

Parameters:
- VOTE_N, 5, number of accepted decisions per vote window (1..15).
- HOLD_CYCLES, 1000, clk cycles the result is held in SHOW before auto re-arm (>=2).
- AUTO_REARM, 1, 1 = return to COLLECT when the hold timer expires; 0 = stay in SHOW until rearm.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; leaves IDLE and begins the first collection.
- rearm  in  1  pulse; aborts or ends the current window and restarts collection.
- valid_in  in  1  decision qualifier from the classifier.
- decision  in  3  3'd0 = smoking, 3'd1 = non-smoking, any other value = error.
- hex  out  7  segment drive, active-low (bit0 = seg a).
- result  out  2  last resolved class: 0 non-smoking, 1 smoking, 2 error, 3 none.
- valid_out  out  1  one-cycle pulse when a new result is shown.
- busy  out  1  high while in COLLECT.

Behaviour:
- Reset (rst=1 at a clk edge) produces the following state:
  - state = IDLE, hex = 7'b1111111 (blank), result = 2'd3, valid_out = 0.
  - All counters = 0.
  - Reset has priority over every other input in any state, including mid-window and mid-hold.
- Segment codes:
  - '0' = 7'b1000000.
  - '1' = 7'b1111001.
  - 'E' = 7'b0000110.
  - blank = 7'b1111111.
- IDLE:
  - hex is blank; valid_in is ignored.
  - start=1 -> COLLECT next cycle, with sample_cnt, smoke_cnt and err_cnt cleared.
  - rearm in IDLE behaves like start.
- COLLECT:
  - busy = 1. Each cycle with valid_in=1 is one accepted sample; there is no backpressure and every valid cycle counts.
  - Per accepted sample: sample_cnt +1. smoke_cnt +1 if decision==0. err_cnt +1 if decision>1.
  - Counters are 4 bits wide and saturate rather than wrap.
  - hex keeps its previous value during collection (blank on the first window).
  - rearm=1 clears all counters and stays in COLLECT. If valid_in is high in the same cycle, that sample is dropped (rearm wins).
  - On the edge that accepts the VOTE_N-th sample, the counts are final. On the following edge the block enters SHOW, loads hex and result, and pulses valid_out. Latency is 1 cycle from the last sample to the new hex.
- Vote resolution, evaluated on the final counts:
  - err_cnt != 0 -> 'E', result = 2.
  - Else 2*smoke_cnt > VOTE_N -> '1', result = 1.
  - Else '0', result = 0. An exact tie with even VOTE_N resolves to non-smoking.
- SHOW:
  - busy = 0; valid_in is ignored (no sample is carried over into the next window); hex and result are frozen.
  - hold_cnt starts at 0 on entry and increments every cycle.
  - AUTO_REARM=1: when hold_cnt == HOLD_CYCLES-1, go to COLLECT next cycle with counters cleared. The result therefore stays visible exactly HOLD_CYCLES cycles before collection restarts.
  - AUTO_REARM=0: hold_cnt saturates and the block stays in SHOW.
  - rearm=1 -> COLLECT next cycle regardless of hold_cnt. rearm coinciding with hold expiry produces a single transition.
  - start in SHOW is ignored.
- valid_out:
  - Asserted only on the single cycle SHOW is entered, and never in any other cycle.
  - Back-to-back windows give one pulse per window.
- hold_cnt width is clog2(HOLD_CYCLES)+1.

Test Plan:
1. rst, start, then 5 valid samples of decision=0,0,1,0,1 on consecutive cycles:
   - hex = 7'b1111001 and result = 1 one cycle after the 5th sample.
   - valid_out is high for exactly 1 cycle; busy falls the same cycle.
2. Window 1,1,1,0,0 with gaps of idle cycles between samples:
   - hex = 7'b1000000, result = 0.
   - Idle cycles do not advance sample_cnt.
3. Window containing one decision=3'd5 among four 0s:
   - hex = 7'b0000110, result = 2.
4. AUTO_REARM=1, HOLD_CYCLES=8:
   - After the result, hex stays constant for 8 cycles, then busy=1.
   - valid_in pulses during SHOW are ignored (the next window still needs 5 new samples).
5. rearm asserted after 3 samples, on the same cycle as a valid_in:
   - Counters clear and that sample is dropped.
   - The result appears only after 5 further samples.
6. rst asserted mid-COLLECT and mid-SHOW:
   - Next cycle hex = 7'b1111111, result = 3, busy = 0.
   - valid_in is ignored until start.

Source files
------------

// File: rtl/cnn_result_display_ctrl.sv
// cnn_result_display_ctrl: majority-votes a window of classifier decisions and shows the result on one 7-seg digit.
// Latency: the new digit appears 1 cycle after the edge that accepts the last sample of a window.
// Backpressure: none; every valid_in cycle in COLLECT is a sample, valid_in is ignored in IDLE and SHOW.
//
// Ports: clk/rst (sync, active-high); start, rearm (pulses); valid_in + decision (3b, 0=smoking,
//        1=non-smoking, else error); hex (active-low segments, bit0 = a); result (0 non-smoking,
//        1 smoking, 2 error, 3 none); valid_out (one pulse per shown result); busy (high in COLLECT).
module cnn_result_display_ctrl #(
  parameter int VOTE_N      = 5,
  parameter int HOLD_CYCLES = 1000,
  parameter int AUTO_REARM  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rearm,
  input  logic       valid_in,
  input  logic [2:0] decision,
  output logic [6:0] hex,
  output logic [1:0] result,
  output logic       valid_out,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_SHOW    = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0]    VOTE_LAST = 4'(VOTE_N);
  localparam logic [4:0]    VOTE_CMP  = 5'(VOTE_N);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  logic [1:0]    state;
  logic [3:0]    sample_cnt;
  logic [3:0]    smoke_cnt;
  logic [3:0]    err_cnt;
  logic [HW-1:0] hold_cnt;

  logic       window_done;
  logic       hold_expired;
  logic [6:0] vote_hex;
  logic [1:0] vote_result;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign busy = (state == S_COLLECT);

  // Counts are final once sample_cnt reaches VOTE_N; the SHOW transition happens on the next edge.
  assign window_done  = (sample_cnt == VOTE_LAST);
  assign hold_expired = (AUTO_REARM != 0) && (hold_cnt == HOLD_LAST);

  // Any error in the window wins; an exact tie resolves to non-smoking.
  always_comb begin
    vote_hex    = SEG_0;
    vote_result = 2'd0;
    if (err_cnt != 4'd0) begin
      vote_hex    = SEG_E;
      vote_result = 2'd2;
    end else if ({smoke_cnt, 1'b0} > VOTE_CMP) begin
      vote_hex    = SEG_1;
      vote_result = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      smoke_cnt  <= '0;
      err_cnt    <= '0;
      hold_cnt   <= '0;
      hex        <= SEG_BLANK;
      result     <= 2'd3;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || rearm) begin
            state      <= S_COLLECT;
            sample_cnt <= '0;
            smoke_cnt  <= '0;
            err_cnt    <= '0;
          end
        end
        S_COLLECT: begin
          if (rearm) begin
            // rearm beats a coincident sample and also a window that just completed
            sample_cnt <= '0;
            smoke_cnt  <= '0;
            err_cnt    <= '0;
          end else if (window_done) begin
            state     <= S_SHOW;
            hex       <= vote_hex;
            result    <= vote_result;
            valid_out <= 1'b1;
            hold_cnt  <= '0;
          end else if (valid_in) begin
            sample_cnt <= sat_inc(sample_cnt);
            if (decision == 3'd0) smoke_cnt <= sat_inc(smoke_cnt);
            if (decision > 3'd1)  err_cnt   <= sat_inc(err_cnt);
          end
        end
        S_SHOW: begin
          if (rearm || hold_expired) begin
            state      <= S_COLLECT;
            sample_cnt <= '0;
            smoke_cnt  <= '0;
            err_cnt    <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_result_display_ctrl.sv
// tb_cnn_result_display_ctrl: directed checks of voting, hold timing, rearm and reset for the display controller.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_cnn_result_display_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rearm;
  logic       valid_in;
  logic [2:0] decision;
  logic [6:0] hex;
  logic [1:0] result;
  logic       valid_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  cnn_result_display_ctrl #(
    .VOTE_N(5),
    .HOLD_CYCLES(8),
    .AUTO_REARM(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rearm(rearm),
    .valid_in(valid_in),
    .decision(decision),
    .hex(hex),
    .result(result),
    .valid_out(valid_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [2:0] d);
    valid_in = 1'b1;
    decision = d;
    step();
    valid_in = 1'b0;
    decision = 3'd0;
  endtask

  task automatic chk_show(input string tag, input logic [6:0] h, input logic [1:0] r);
    chk({tag, "_hex"}, 32'(hex), 32'(h));
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_vout"}, 32'(valid_out), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rearm = 1'b0; valid_in = 1'b0; decision = 3'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_hex", 32'(hex), 32'(SEG_BLANK));
    chk("rst_result", 32'(result), 32'd3);
    chk("rst_vout", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: consecutive 0,0,1,0,1 -> three smoking of five -> '1'
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_hex_blank", 32'(hex), 32'(SEG_BLANK));
    sample(3'd0); sample(3'd0); sample(3'd1); sample(3'd0); sample(3'd1);
    chk("t1_last_busy", 32'(busy), 32'd1);
    chk("t1_last_vout", 32'(valid_out), 32'd0);
    step();
    chk_show("t1", SEG_1, 2'd1);

    // 4: hold for 8 cycles, SHOW ignores valid_in
    for (int i = 1; i < 8; i++) begin
      valid_in = 1'b1; decision = 3'd0;
      step();
      valid_in = 1'b0;
      chk("t4_hold_busy", 32'(busy), 32'd0);
      chk("t4_hold_vout", 32'(valid_out), 32'd0);
      chk("t4_hold_hex", 32'(hex), 32'(SEG_1));
    end
    step();
    chk("t4_rearm_busy", 32'(busy), 32'd1);
    chk("t4_rearm_hex", 32'(hex), 32'(SEG_1));

    // 2: 1,1,1,0,0 with idle gaps -> '0'
    sample(3'd1); step();
    sample(3'd1); step(); step();
    sample(3'd1);
    sample(3'd0); step(); step(); step();
    chk("t2_gap_busy", 32'(busy), 32'd1);
    chk("t2_gap_vout", 32'(valid_out), 32'd0);
    sample(3'd0);
    step();
    chk_show("t2", SEG_0, 2'd0);

    // 3: rearm out of SHOW, then one error among four smoking -> 'E'
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_hex_kept", 32'(hex), 32'(SEG_0));
    sample(3'd0); sample(3'd0); sample(3'd5); sample(3'd0); sample(3'd0);
    step();
    chk_show("t3", SEG_E, 2'd2);

    // 5: rearm with coincident sample after 3 smoking samples; then 5 non-smoking -> '0'
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    sample(3'd0); sample(3'd0); sample(3'd0);
    rearm = 1'b1; valid_in = 1'b1; decision = 3'd0;
    step();
    rearm = 1'b0; valid_in = 1'b0;
    sample(3'd1); sample(3'd1); sample(3'd1); sample(3'd1);
    step();
    chk("t5_4_busy", 32'(busy), 32'd1);
    chk("t5_4_vout", 32'(valid_out), 32'd0);
    sample(3'd1);
    step();
    chk_show("t5", SEG_0, 2'd0);

    // 6a: reset mid-SHOW, then valid_in ignored in IDLE
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6a_hex", 32'(hex), 32'(SEG_BLANK));
    chk("t6a_result", 32'(result), 32'd3);
    chk("t6a_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) sample(3'd0);
    step();
    chk("t6a_idle_busy", 32'(busy), 32'd0);
    chk("t6a_idle_vout", 32'(valid_out), 32'd0);
    chk("t6a_idle_hex", 32'(hex), 32'(SEG_BLANK));

    // 6b: reset mid-COLLECT
    start = 1'b1; step(); start = 1'b0;
    sample(3'd0); sample(3'd0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6b_hex", 32'(hex), 32'(SEG_BLANK));
    chk("t6b_result", 32'(result), 32'd3);
    chk("t6b_busy", 32'(busy), 32'd0);

    // rearm in IDLE acts as start; then rearm coinciding with hold expiry gives one transition
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("idle_rearm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) sample(3'd0);
    step();
    chk_show("t7", SEG_1, 2'd1);
    for (int i = 1; i < 8; i++) step();
    chk("t7_pre_busy", 32'(busy), 32'd0);
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("t7_exp_busy", 32'(busy), 32'd1);
    chk("t7_exp_vout", 32'(valid_out), 32'd0);
    step();
    chk("t7_still_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
